// File: rtl/pipearch_read_reorder.sv
// Read-response reorder buffer: accepts cache-line responses in any order
// within a sliding window of DEPTH lines and emits them strictly in sequence.
module pipearch_read_reorder #(
   parameter int LOG2_DEPTH = 6
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  op_start,
   input  logic [31:0]           op_length,
   input  logic                  in_valid,
   input  logic [15:0]           in_mdata,
   input  logic [1:0]            in_cl_num,
   input  logic [511:0]          in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [511:0]          out_data,
   output logic [31:0]           out_index,
   output logic [LOG2_DEPTH:0]   free_slots,
   output logic                  op_done,
   output logic                  error
);
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam logic [DEPTH-1:0]    OCC_ONE   = 1;
   localparam logic [LOG2_DEPTH:0] FREE_ONE  = 1;
   localparam logic [LOG2_DEPTH:0] FREE_FULL = (LOG2_DEPTH+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              r_state, w_state_next;
   logic [31:0]         r_len, r_emitted;
   logic [15:0]         r_head;
   logic [DEPTH-1:0]    r_occ;
   logic [LOG2_DEPTH:0] r_free;
   logic                r_error;
   logic [511:0]        r_mem [DEPTH];
   logic [511:0]        r_rd_data;
   logic                r_rd_valid;
   logic [511:0]        r_fifo_mem [2];
   logic                r_fifo_wr, r_fifo_rd;
   logic [1:0]          r_fifo_cnt;

   logic [15:0]           w_index, w_dist;
   logic [LOG2_DEPTH-1:0] w_slot, w_head_slot;
   logic                  w_in_window, w_start, w_accept, w_reject;
   logic                  w_room, w_drain, w_active, w_fifo_ne;
   logic                  w_fire, w_push, w_pop;
   logic [DEPTH-1:0]      w_set_mask, w_clr_mask;

   // Window test is done on the 16-bit distance so head wrap is handled for free.
   assign w_index     = in_mdata + {14'd0, in_cl_num};
   assign w_slot      = w_index[LOG2_DEPTH-1:0];
   assign w_dist      = w_index - r_head;
   assign w_in_window = (w_dist >> LOG2_DEPTH) == 16'd0;
   assign w_head_slot = r_head[LOG2_DEPTH-1:0];

   assign w_start  = (r_state == S_IDLE) && op_start;
   assign w_accept = (r_state == S_RUN) && in_valid && !r_occ[w_slot] && w_in_window;
   assign w_reject = in_valid && !w_accept;

   // At most two lines may sit between the RAM and the consumer (FIFO + read in flight).
   assign w_room  = (r_fifo_cnt == 2'd0) || ((r_fifo_cnt == 2'd1) && !r_rd_valid);
   assign w_drain = (r_state == S_RUN) && r_occ[w_head_slot] && w_room;

   // The RAM output register bypasses the FIFO when the FIFO is empty,
   // giving two-cycle latency and one line per cycle under full flow.
   assign w_fifo_ne = (r_fifo_cnt != 2'd0);
   assign w_active  = (r_state == S_RUN) && (r_emitted != r_len);
   assign out_valid = w_active && (w_fifo_ne || r_rd_valid);
   assign out_data  = w_fifo_ne ? r_fifo_mem[r_fifo_rd] : r_rd_data;
   assign w_fire    = out_valid && out_ready;
   assign w_pop     = w_fire && w_fifo_ne;
   assign w_push    = r_rd_valid && !(w_fire && !w_fifo_ne);

   assign w_set_mask = w_accept ? (OCC_ONE << w_slot) : '0;
   assign w_clr_mask = w_drain ? (OCC_ONE << w_head_slot) : '0;

   assign out_index  = r_emitted;
   assign free_slots = r_free;
   assign op_done    = (r_state == S_DONE);
   assign error      = r_error;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   // Next-state logic: IDLE -> RUN on start, RUN -> DONE once every line is out.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (op_start) w_state_next = S_RUN;
         S_RUN:   if (r_emitted == r_len) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Control state: counters, occupancy, output FIFO bookkeeping and error flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_len      <= '0;
         r_emitted  <= '0;
         r_head     <= '0;
         r_occ      <= '0;
         r_free     <= FREE_FULL;
         r_error    <= 1'b0;
         r_rd_valid <= 1'b0;
         r_fifo_cnt <= '0;
         r_fifo_wr  <= 1'b0;
         r_fifo_rd  <= 1'b0;
      end else if (w_start) begin
         r_len      <= op_length;
         r_emitted  <= '0;
         r_head     <= '0;
         r_occ      <= '0;
         r_free     <= FREE_FULL;
         r_error    <= 1'b0;
         r_rd_valid <= 1'b0;
         r_fifo_cnt <= '0;
         r_fifo_wr  <= 1'b0;
         r_fifo_rd  <= 1'b0;
      end else begin
         if (w_drain) r_head <= r_head + 16'd1;
         if (w_fire)  r_emitted <= r_emitted + 32'd1;
         r_occ      <= (r_occ | w_set_mask) & ~w_clr_mask;
         r_error    <= r_error | w_reject;
         r_rd_valid <= w_drain;
         // A slot counts as taken from acceptance until the line leaves the block.
         case ({w_accept, w_fire})
            2'b10:   r_free <= r_free - FREE_ONE;
            2'b01:   r_free <= r_free + FREE_ONE;
            default: r_free <= r_free;
         endcase
         if (w_push) r_fifo_wr <= ~r_fifo_wr;
         if (w_pop)  r_fifo_rd <= ~r_fifo_rd;
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   // Line storage with registered read; contents need no reset.
   always_ff @(posedge clk) begin
      if (w_accept) r_mem[w_slot] <= in_data;
      if (w_drain)  r_rd_data <= r_mem[w_head_slot];
   end

   // Output FIFO payload storage.
   always_ff @(posedge clk) begin
      if (w_push) r_fifo_mem[r_fifo_wr] <= r_rd_data;
   end
endmodule

// File: tb/tb_pipearch_read_reorder.sv
// Bench for pipearch_read_reorder: directed scenarios plus randomized
// out-of-order traffic, checked by a scoreboard fed from a reorder model.
module tb_pipearch_read_reorder;
   localparam int LOG2_DEPTH = 6;
   localparam int DEPTH = 1 << LOG2_DEPTH;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                op_start;
   logic [31:0]         op_length;
   logic                in_valid;
   logic [15:0]         in_mdata;
   logic [1:0]          in_cl_num;
   logic [511:0]        in_data;
   logic                out_valid;
   logic                out_ready;
   logic [511:0]        out_data;
   logic [31:0]         out_index;
   logic [LOG2_DEPTH:0] free_slots;
   logic                op_done;
   logic                error;

   pipearch_read_reorder #(.LOG2_DEPTH(LOG2_DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_length(op_length),
      .in_valid(in_valid), .in_mdata(in_mdata), .in_cl_num(in_cl_num), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .free_slots(free_slots), .op_done(op_done), .error(error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           idx;
      logic [511:0] data;
   } exp_t;

   exp_t         exp_q[$];
   bit           got[int];
   logic [511:0] mdl_data[int];
   int           next_exp;
   int           mdl_len;
   bit           exp_err;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int done_before = 0;
   int fires = 0;
   int first_valid_cyc = -1;
   int first_fire_cyc = -1;
   int last_fire_cyc = -1;
   int line0_cyc = -1;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a line is kept if it is new and lies within DEPTH of the
   // oldest missing line; every time the contiguous prefix grows, those lines
   // become the next expected outputs.
   task automatic model_issue(input int idx, input logic [511:0] d, output bit acc);
      acc = 1'b0;
      if (!got.exists(idx) && idx < next_exp + DEPTH) begin
         acc = 1'b1;
         got[idx] = 1'b1;
         mdl_data[idx] = d;
         while (got.exists(next_exp)) begin
            if (next_exp < mdl_len) exp_q.push_back('{next_exp, mdl_data[next_exp]});
            next_exp++;
         end
      end
   endtask

   task automatic send_line(input int mdata, input int cl);
      logic [511:0] d;
      int idx;
      bit acc;
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
      idx = mdata + cl;
      in_valid  = 1'b1;
      in_mdata  = mdata[15:0];
      in_cl_num = cl[1:0];
      in_data   = d;
      if (idx == 0 && line0_cyc < 0) line0_cyc = cyc;
      model_issue(idx, d, acc);
      if (!acc) exp_err = 1'b1;
      $display("in  idx=%0d mdata=%0d cl=%0d kept=%0d", idx, mdata, cl, acc);
      step();
      in_valid = 1'b0;
   endtask

   task automatic start_op(input int len);
      exp_q.delete();
      got.delete();
      mdl_data.delete();
      next_exp = 0;
      mdl_len = len;
      exp_err = 1'b0;
      fires = 0;
      first_valid_cyc = -1;
      first_fire_cyc = -1;
      last_fire_cyc = -1;
      line0_cyc = -1;
      done_before = done_cnt;
      op_start  = 1'b1;
      op_length = len;
      $display("op  start length=%0d", len);
      step();
      op_start = 1'b0;
   endtask

   task automatic finish_op(input string name, input int exp_fires);
      int n;
      n = 0;
      while (done_cnt == done_before && n < 3000) begin
         step();
         n++;
      end
      chk({name, "_done_seen"}, (done_cnt != done_before), 1);
      repeat (3) step();
      chk({name, "_done_once"}, done_cnt - done_before, 1);
      chk({name, "_transfers"}, fires, exp_fires);
      chk({name, "_sb_empty"}, exp_q.size(), 0);
      chk({name, "_error"}, error, exp_err);
      chk({name, "_free"}, free_slots, DEPTH);
      chk({name, "_idle_valid"}, out_valid, 0);
   endtask

   // Monitor: samples at the falling edge, so it sees exactly what the DUT
   // will act on at the next rising edge.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (op_done) done_cnt++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
               if (fires == 0) first_fire_cyc = cyc;
               last_fire_cyc = cyc;
               fires++;
               $display("out idx=%0d", out_index);
               if (exp_q.size() == 0) begin
                  chk("unexpected_output", out_index, 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_index", out_index, e.idx);
                  chk("out_data", out_data, e.data);
               end
            end
         end
      end
   endtask

   task automatic run_random(input int len);
      bit sent[];
      int nsent, guard, base, hi, k, cl;
      bit found;
      sent = new[len];
      start_op(len);
      nsent = 0;
      guard = 0;
      while (nsent < len && guard < 20000) begin
         guard++;
         out_ready = ($urandom_range(0, 3) != 0);
         found = 1'b0;
         if ($urandom_range(0, 4) != 0) begin
            base = fires;
            hi = (fires + DEPTH < len) ? fires + DEPTH : len;
            k = $urandom_range(base, hi - 1);
            for (int j = 0; j < hi - base && !found; j++) begin
               if (!sent[k]) found = 1'b1;
               else k = (k + 1 < hi) ? k + 1 : base;
            end
         end
         if (found) begin
            sent[k] = 1'b1;
            nsent++;
            cl = $urandom_range(0, (k < 3) ? k : 3);
            send_line(k - cl, cl);
         end else begin
            step();
         end
      end
      chk("rand_all_sent", nsent, len);
      out_ready = 1'b1;
      finish_op("rand", len);
   endtask

   initial begin
      reset_n   = 1'b0;
      op_start  = 1'b0;
      op_length = '0;
      in_valid  = 1'b0;
      in_mdata  = '0;
      in_cl_num = '0;
      in_data   = '0;
      out_ready = 1'b1;
      fork
         monitor();
      join_none
      repeat (3) step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_op_done", op_done, 0);
      chk("rst_error", error, 0);
      chk("rst_free", free_slots, DEPTH);
      chk("rst_index", out_index, 0);
      reset_n = 1'b1;
      step();

      // In order, one line per cycle.
      start_op(8);
      for (int i = 0; i < 8; i++) send_line(i, 0);
      finish_op("inorder", 8);
      chk("inorder_latency", first_valid_cyc - line0_cyc, 2);
      chk("inorder_back_to_back", last_fire_cyc - first_fire_cyc, 7);

      // Reverse order: nothing until line 0, then a burst.
      start_op(4);
      for (int i = 3; i >= 0; i--) send_line(i, 0);
      finish_op("reverse", 4);
      chk("reverse_latency", first_valid_cyc - line0_cyc, 2);
      chk("reverse_back_to_back", last_fire_cyc - first_fire_cyc, 3);

      // Multi-line responses.
      start_op(8);
      send_line(4, 3);
      send_line(4, 1);
      send_line(4, 0);
      send_line(4, 2);
      for (int i = 0; i < 4; i++) send_line(i, 0);
      finish_op("multiline", 8);

      // Backpressure; an op_start mid-run must be ignored.
      out_ready = 1'b0;
      start_op(10);
      for (int i = 9; i >= 0; i--) send_line(i, 0);
      op_start  = 1'b1;
      op_length = 3;
      step();
      op_start = 1'b0;
      repeat (9) step();
      chk("bp_free", free_slots, DEPTH - 10);
      chk("bp_no_transfer", fires, 0);
      out_ready = 1'b1;
      finish_op("backpressure", 10);

      // Protocol errors: duplicate and out-of-window lines are dropped.
      start_op(8);
      send_line(5, 0);
      send_line(5, 0);
      step();
      chk("err_after_dup", error, 1);
      send_line(64, 0);
      step();
      chk("err_sticky", error, 1);
      for (int i = 0; i < 8; i++) if (i != 5) send_line(i, 0);
      finish_op("errors", 8);

      // Reset in the middle of an operation.
      out_ready = 1'b0;
      start_op(8);
      for (int i = 0; i < 3; i++) send_line(i, 0);
      step();
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      chk("midrst_valid", out_valid, 0);
      chk("midrst_free", free_slots, DEPTH);
      chk("midrst_done", op_done, 0);
      step();
      reset_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) step();
      chk("midrst_quiet", out_valid, 0);
      start_op(2);
      send_line(1, 0);
      send_line(0, 0);
      finish_op("after_reset", 2);

      // Line arriving while idle flags an error that op_start clears.
      in_valid = 1'b1;
      in_mdata = 16'd0;
      step();
      in_valid = 1'b0;
      step();
      chk("idle_in_error", error, 1);
      start_op(1);
      chk("start_clears_error", error, 0);
      send_line(0, 0);
      finish_op("single", 1);

      // Zero-length operation.
      start_op(0);
      finish_op("zero_len", 0);

      // Randomized out-of-order traffic with random backpressure.
      for (int r = 0; r < 4; r++) run_random($urandom_range(40, 150));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
